// File: rtl/dbus_pkg.sv
// Data-bus handshake types shared by requesters and responders.
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// Shared state encoding and LFSR constants for the SRAM data-bus responder.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} dbus_sram_state_t;

  localparam logic [7:0] DBUS_SRAM_LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] DBUS_SRAM_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/dbus_sram_responder_lfsr8.sv
// 8-bit Fibonacci LFSR advancing every cycle; drives the optional random stall.
module lfsr8
  import dbus_sram_responder_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] out
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & DBUS_SRAM_LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= DBUS_SRAM_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// SRAM-backed data-bus responder with fixed response latency.
// Define DBUS_SRAM_RANDOM_STALL_EN to add LFSR-driven random stalls in WAIT.
module dbus_sram_responder
  import dbus_pkg::*;
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned IdxW = $clog2(DEPTH);

`ifdef DBUS_SRAM_RANDOM_STALL_EN
  // Always pass through WAIT so stalls also apply when LATENCY is 1.
  localparam bit         DirectResp = 1'b0;
  localparam logic [3:0] CntInit    = (LATENCY == 1) ? 4'd1 : 4'(LATENCY - 1);
`else
  localparam bit         DirectResp = (LATENCY == 1);
  localparam logic [3:0] CntInit    = 4'(LATENCY - 1);
`endif

  dbus_sram_state_t state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      mem [DEPTH];

  logic [IdxW-1:0]  idx;
  logic             accept;
  logic             wr_en;
  logic             stall;
  logic             data_ok;

  assign idx    = dreq.addr[IdxW+1:2];
  assign accept = resetn && (state_q == StIdle) && dreq.valid;
  assign wr_en  = accept && (|dreq.strobe);

  // Lane selection comes from strobe; size, low and upper address bits are don't-care.
  logic unused_req;
  assign unused_req = ^{dreq.size, dreq.addr[1:0], dreq.addr[31:IdxW+2]};

`ifdef DBUS_SRAM_RANDOM_STALL_EN
  logic [7:0] lfsr_val;
  logic       unused_lfsr;

  lfsr8 u_lfsr8 (
    .clk    (clk),
    .resetn (resetn),
    .out    (lfsr_val)
  );

  assign stall       = lfsr_val[0];
  assign unused_lfsr = ^lfsr_val[7:1];
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dreq.strobe[i]) begin
          mem[idx][8*i +: 8] <= dreq.data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = wr_en ? '0 : mem[idx];
          if (DirectResp) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        // Requester flush wins over stall and countdown.
        if (!dreq.valid) begin
          state_d = StIdle;
        end else if (!stall) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    data_ok       = (state_q == StResp) && dreq.valid;
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = data_ok;
    dresp.data    = data_ok ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench: one responder at LATENCY=2, one at LATENCY=1.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic       clk;
  logic       resetn;
  dbus_req_t  req0, req1;
  dbus_resp_t resp0, resp1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned sel     = 0;

  dbus_sram_responder #(
    .DEPTH   (1024),
    .LATENCY (2)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .dreq   (req0),
    .dresp  (resp0)
  );

  dbus_sram_responder #(
    .DEPTH   (1024),
    .LATENCY (1)
  ) u_dut1 (
    .clk    (clk),
    .resetn (resetn),
    .dreq   (req1),
    .dresp  (resp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
    dbus_req_t r;
    r        = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'd2;
    r.strobe = s;
    r.data   = d;
    if (sel == 0) req0 = r;
    else          req1 = r;
  endtask

  function automatic dbus_resp_t cur_resp();
    return (sel == 0) ? resp0 : resp1;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following data_ok.
  task automatic xfer(input string tag, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp);
    int unsigned lat;
    int unsigned exp_lat;
    bit          got;
    exp_lat = (sel == 0) ? 2 : 1;
    set_req(1'b1, a, s, d);
    @(negedge clk);
    check_eq({tag, "_aok"}, 32'(cur_resp().addr_ok), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (cur_resp().data_ok) got = 1'b1;
    end
    check_eq({tag, "_got"}, 32'(got), 32'd1);
`ifdef DBUS_SRAM_RANDOM_STALL_EN
    check_eq({tag, "_lat"}, 32'(lat >= exp_lat), 32'd1);
`else
    check_eq({tag, "_lat"}, lat, exp_lat);
`endif
    check_eq({tag, "_data"}, cur_resp().data, exp);
    @(posedge clk);
    #1;
    set_req(1'b0, a, s, d);
  endtask

  logic [31:0] words [4];
  int unsigned nreads;
  int unsigned cyc;
  bit          exp_aok;

  initial begin
    resetn = 1'b0;
    req0   = '0;
    req1   = '0;
    sel    = 0;
    set_req(1'b1, 32'h10, 4'b0000, 32'h0);

    // Outputs stay quiet under reset even with valid asserted.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_aok", 32'(resp0.addr_ok), 32'd0);
      check_eq("rst_dok", 32'(resp0.data_ok), 32'd0);
      check_eq("rst_data", resp0.data, 32'd0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rst_first_aok", 32'(resp0.addr_ok), 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 32'h10, 4'b0000, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_flush_dok", 32'(resp0.data_ok), 32'd0);
    end
    @(posedge clk);
    #1;

    xfer("wr10", 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0);
    xfer("rd10", 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF);

    xfer("wr20a", 32'h20, 4'b1111, 32'h11223344, 32'h0);
    xfer("wr20b", 32'h20, 4'b0001, 32'h000000AA, 32'h0);
    xfer("wr20c", 32'h20, 4'b1000, 32'hBB000000, 32'h0);
    xfer("rd20", 32'h20, 4'b0000, 32'h0, 32'hBB2233AA);

    xfer("wr1004", 32'h00001004, 4'b1111, 32'h5A5A5A5A, 32'h0);
    xfer("rd0004", 32'h00000004, 4'b0000, 32'h0, 32'h5A5A5A5A);

    // Read abort: valid dropped one cycle after acceptance.
    set_req(1'b1, 32'h10, 4'b0000, 32'h0);
    @(negedge clk);
    check_eq("abort_aok", 32'(resp0.addr_ok), 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 32'h10, 4'b0000, 32'h0);
    @(negedge clk);
    check_eq("abort_dok", 32'(resp0.data_ok), 32'd0);
    @(posedge clk);
    #1;
    xfer("abort_next", 32'h20, 4'b0000, 32'h0, 32'hBB2233AA);

    // Aborted write still lands in the array.
    set_req(1'b1, 32'h30, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("wabort_aok", 32'(resp0.addr_ok), 32'd1);
    @(posedge clk);
    #1;
    set_req(1'b0, 32'h30, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("wabort_dok", 32'(resp0.data_ok), 32'd0);
    @(posedge clk);
    #1;
    xfer("wabort_rd", 32'h30, 4'b0000, 32'h0, 32'hCAFEF00D);

    // LATENCY=1 instance: load four words, then stream reads with valid held.
    sel = 1;
    words[0] = 32'h0000_1111;
    words[1] = 32'h2222_0000;
    words[2] = 32'h3333_4444;
    words[3] = 32'h5555_6666;
    for (int i = 0; i < 4; i++) begin
      xfer("l1_wr", 32'h40 + 32'(4 * i), 4'b1111, words[i], 32'h0);
    end

    nreads  = 0;
    cyc     = 0;
    exp_aok = 1'b1;
    set_req(1'b1, 32'h40, 4'b0000, 32'h0);
    while (nreads < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check_eq("b2b_excl", 32'(resp1.addr_ok && resp1.data_ok), 32'd0);
`ifndef DBUS_SRAM_RANDOM_STALL_EN
      check_eq("b2b_alt", 32'(resp1.addr_ok), 32'(exp_aok));
      exp_aok = !exp_aok;
`endif
      if (resp1.data_ok) begin
        check_eq("b2b_data", resp1.data, words[nreads]);
        nreads++;
        @(posedge clk);
        #1;
        if (nreads < 4) set_req(1'b1, 32'h40 + 32'(4 * nreads), 4'b0000, 32'h0);
        else            set_req(1'b0, 32'h40, 4'b0000, 32'h0);
      end
    end
    check_eq("b2b_count", nreads, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
